mem_access_stage: RTL and testbench

- MEM stage of the 5-stage RV32I core. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Consumes the EX/MEM outputs: ALU result, rs2, exec code, rdest and we.
- Performs loads and stores over the core's 8-bit byte-serial memory-controller port, one byte per handshake.
- While a multi-cycle access is in flight it raises a stall request, so EX/MEM and earlier stages hold, and it delivers the write-back value to MEM/WB.

---
 rtl/mem_access_stage.sv | 154 +++++++++++++++
 tb/tb_mem_access_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: byte-serial loads/stores over the 8-bit memory port.
// Stalls upstream while an access is in flight; one-cycle DONE delivers the result.
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] exmem_alu_in,
    input  logic [DATA_W-1:0] exmem_rs2_in,
    input  logic [4:0]        exmem_exec_in,
    input  logic [4:0]        exmem_rdest_in,
    input  logic              exmem_we_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              stall_req,
    output logic [DATA_W-1:0] mem_wdata_out,
    output logic [4:0]        mem_rdest_out,
    output logic              mem_we_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [4:0] OP_LB  = 5'd1;
    localparam logic [4:0] OP_LH  = 5'd2;
    localparam logic [4:0] OP_LW  = 5'd3;
    localparam logic [4:0] OP_LBU = 5'd4;
    localparam logic [4:0] OP_LHU = 5'd5;
    localparam logic [4:0] OP_SB  = 5'd6;
    localparam logic [4:0] OP_SH  = 5'd7;
    localparam logic [4:0] OP_SW  = 5'd8;

    state_t            state;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] asm_q;
    logic [4:0]        op_q;
    logic [4:0]        rdest_q;
    logic              we_q;

    function automatic logic is_mem(input logic [4:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] last_idx(input logic [4:0] op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            OP_LW, OP_SW:         return 2'd3;
            default:              return 2'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            asm_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= 5'd0;
            rdest_q <= 5'd0;
            we_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem(exmem_exec_in)) begin
                        addr_q  <= exmem_alu_in[ADDR_W-1:0];
                        data_q  <= exmem_rs2_in;
                        op_q    <= exmem_exec_in;
                        rdest_q <= exmem_rdest_in;
                        we_q    <= exmem_we_in;
                        cnt     <= 2'd0;
                        asm_q   <= '0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!is_store(op_q))
                            asm_q[{cnt, 3'b000} +: 8] <= mem_rdata;
                        if (cnt == last_idx(op_q))
                            state <= DONE;
                        else
                            cnt <= cnt + 2'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] load_val;

    always_comb begin
        case (op_q)
            OP_LB:   load_val = {{(DATA_W-8){asm_q[7]}}, asm_q[7:0]};
            OP_LBU:  load_val = {{(DATA_W-8){1'b0}}, asm_q[7:0]};
            OP_LH:   load_val = {{(DATA_W-16){asm_q[15]}}, asm_q[15:0]};
            OP_LHU:  load_val = {{(DATA_W-16){1'b0}}, asm_q[15:0]};
            default: load_val = asm_q;
        endcase
    end

    // Outputs are forced low while rst is asserted, even before the reset edge.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = 8'd0;
        stall_req     = 1'b0;
        mem_wdata_out = '0;
        mem_rdest_out = 5'd0;
        mem_we_out    = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (is_mem(exmem_exec_in)) begin
                        stall_req = 1'b1;
                    end else begin
                        mem_wdata_out = exmem_alu_in;
                        mem_rdest_out = exmem_rdest_in;
                        mem_we_out    = exmem_we_in;
                    end
                end
                ACCESS: begin
                    mem_req   = 1'b1;
                    stall_req = 1'b1;
                    mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, cnt};
                    mem_we    = is_store(op_q);
                    mem_wdata = data_q[{cnt, 3'b000} +: 8];
                end
                DONE: begin
                    mem_rdest_out = rdest_q;
                    if (!is_store(op_q)) begin
                        mem_wdata_out = load_val;
                        mem_we_out    = we_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] exmem_alu_in;
    logic [31:0] exmem_rs2_in;
    logic [4:0]  exmem_exec_in;
    logic [4:0]  exmem_rdest_in;
    logic        exmem_we_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        stall_req;
    logic [31:0] mem_wdata_out;
    logic [4:0]  mem_rdest_out;
    logic        mem_we_out;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .exmem_alu_in  (exmem_alu_in),
        .exmem_rs2_in  (exmem_rs2_in),
        .exmem_exec_in (exmem_exec_in),
        .exmem_rdest_in(exmem_rdest_in),
        .exmem_we_in   (exmem_we_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .stall_req     (stall_req),
        .mem_wdata_out (mem_wdata_out),
        .mem_rdest_out (mem_rdest_out),
        .mem_we_out    (mem_we_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req"},   32'(mem_req), 32'd0);
        chk({tag, ".we"},    32'(mem_we), 32'd0);
        chk({tag, ".addr"},  mem_addr, 32'd0);
        chk({tag, ".wd"},    32'(mem_wdata), 32'd0);
        chk({tag, ".stall"}, 32'(stall_req), 32'd0);
        chk({tag, ".out"},   mem_wdata_out, 32'd0);
        chk({tag, ".rd"},    32'(mem_rdest_out), 32'd0);
        chk({tag, ".weo"},   32'(mem_we_out), 32'd0);
    endtask

    // Issue one mem op starting on this falling edge; memory answers each
    // byte after lat cycles with the bytes packed little-endian in rbytes.
    task automatic run_mem(input string tag, input logic [4:0] op,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic we,
                           input int n, input int lat,
                           input logic [31:0] rbytes,
                           input logic [31:0] exp_out);
        logic st;
        logic [31:0] ea;
        logic [31:0] rs2_v;
        int cyc;
        st = (op >= 5'd6);
        rs2_v = rs2;
        exmem_exec_in = op;
        exmem_alu_in = addr;
        exmem_rs2_in = rs2;
        exmem_rdest_in = rd;
        exmem_we_in = we;
        #1;
        cyc = 1;
        chk({tag, ".idle_stall"}, 32'(stall_req), 32'd1);
        chk({tag, ".idle_weo"}, 32'(mem_we_out), 32'd0);
        chk({tag, ".idle_req"}, 32'(mem_req), 32'd0);
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < lat; w++) begin
                @(negedge clk);
                cyc++;
                mem_ready = 1'b0;
                ea = addr + 32'(b);
                chk($sformatf("%s.req%0d", tag, b), 32'(mem_req), 32'd1);
                chk($sformatf("%s.addr%0d", tag, b), mem_addr, ea);
                chk($sformatf("%s.we%0d", tag, b), 32'(mem_we), 32'(st));
                chk($sformatf("%s.stall%0d", tag, b), 32'(stall_req), 32'd1);
                if (st)
                    chk($sformatf("%s.wd%0d", tag, b), 32'(mem_wdata),
                        32'(rs2_v[8*b +: 8]));
                if (w == lat - 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = rbytes[8*b +: 8];
                end
            end
        end
        @(negedge clk);
        cyc++;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        chk({tag, ".done_stall"}, 32'(stall_req), 32'd0);
        chk({tag, ".done_req"}, 32'(mem_req), 32'd0);
        chk({tag, ".done_weo"}, 32'(mem_we_out), st ? 32'd0 : 32'(we));
        if (!st) begin
            chk({tag, ".done_out"}, mem_wdata_out, exp_out);
            chk({tag, ".done_rd"}, 32'(mem_rdest_out), 32'(rd));
        end
        chk({tag, ".cycles"}, 32'(cyc), 32'(2 + n * lat));
        exmem_exec_in = 5'd0;
        exmem_alu_in = 32'h0;
        exmem_rdest_in = 5'd0;
        exmem_we_in = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, ".after_idle"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        exmem_exec_in = 5'd8;
        exmem_alu_in = 32'h200;
        exmem_rs2_in = 32'h11223344;
        exmem_rdest_in = 5'd3;
        exmem_we_in = 1'b1;

        // Reset held for three cycles with SW on the inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero($sformatf("rst%0d", i));
        end
        @(negedge clk);
        rst = 1'b0;
        run_mem("sw_after_rst", 5'd8, 32'h200, 32'h11223344, 5'd3, 1'b1,
                4, 1, 32'h0, 32'h0);

        // Pass-through of a non-memory op.
        exmem_exec_in = 5'd0;
        exmem_alu_in = 32'h12345678;
        exmem_rdest_in = 5'd5;
        exmem_we_in = 1'b1;
        #1;
        chk("pt.out", mem_wdata_out, 32'h12345678);
        chk("pt.rd", 32'(mem_rdest_out), 32'd5);
        chk("pt.weo", 32'(mem_we_out), 32'd1);
        chk("pt.stall", 32'(stall_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("pt.req%0d", i), 32'(mem_req), 32'd0);
        end
        exmem_exec_in = 5'd17;
        #1;
        chk("pt_badop.stall", 32'(stall_req), 32'd0);
        chk("pt_badop.out", mem_wdata_out, 32'h12345678);
        @(negedge clk);

        run_mem("lw", 5'd3, 32'h100, 32'h0, 5'd10, 1'b1, 4, 1,
                32'h12345678, 32'h12345678);
        run_mem("lb", 5'd1, 32'h7, 32'h0, 5'd11, 1'b1, 1, 1,
                32'h00000080, 32'hFFFFFF80);
        run_mem("lbu", 5'd4, 32'h7, 32'h0, 5'd12, 1'b1, 1, 1,
                32'h00000080, 32'h00000080);
        run_mem("lh", 5'd2, 32'h21, 32'h0, 5'd13, 1'b1, 2, 1,
                32'h0000F234, 32'hFFFFF234);
        run_mem("lhu", 5'd5, 32'h40, 32'h0, 5'd14, 1'b1, 2, 2,
                32'h0000F234, 32'h0000F234);
        run_mem("sh_wrap", 5'd7, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd0, 1'b0,
                2, 3, 32'h0, 32'h0);
        run_mem("sb", 5'd6, 32'h55, 32'h000000A5, 5'd0, 1'b0, 1, 2,
                32'h0, 32'h0);

        // Reset in the middle of a LW, after two bytes completed.
        exmem_exec_in = 5'd3;
        exmem_alu_in = 32'h300;
        exmem_rdest_in = 5'd7;
        exmem_we_in = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            chk($sformatf("mid.req%0d", b), 32'(mem_req), 32'd1);
            mem_ready = 1'b1;
            mem_rdata = 8'hEE;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        chk("mid.addr2", mem_addr, 32'h302);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        chk("mid.req_after", 32'(mem_req), 32'd0);
        exmem_exec_in = 5'd0;
        exmem_alu_in = 32'h0000ABCD;
        exmem_rdest_in = 5'd9;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mid.no_done_out%0d", i), mem_wdata_out, 32'h0000ABCD);
            chk($sformatf("mid.no_req%0d", i), 32'(mem_req), 32'd0);
            chk($sformatf("mid.no_stall%0d", i), 32'(stall_req), 32'd0);
            @(negedge clk);
        end
        run_mem("lb_after", 5'd1, 32'h9, 32'h0, 5'd4, 1'b1, 1, 1,
                32'h0000007F, 32'h0000007F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
